// File: rtl/program_loader.sv
// Boot loader: hunts for a sync byte, reads a 16-bit word count, streams big-endian
// words into program memory, verifies an XOR checksum, then releases the CPU from reset.
module program_loader #(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        error,
    output logic [15:0] words_loaded
);
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CHECK, DONE, ERROR} state_t;

    localparam logic [15:0] MAX_COUNT = 16'(MEMORY_DEPTH);

    state_t      state, stateNext;
    logic [15:0] count;
    logic [15:0] newCount;
    logic [1:0]  byteIdx;
    logic [23:0] wordAcc;
    logic [7:0]  csum;
    logic        accept;
    logic        lastWord;

    // The write cycle stalls the stream so the header/data path never sees two events at once.
    always_comb begin
        byte_ready = 1'b0;
        if (!reset && !mem_we)
            byte_ready = (state == IDLE) || (state == HDR_HI) || (state == HDR_LO) ||
                         (state == DATA) || (state == CHECK);
    end

    assign accept   = byte_valid && byte_ready;
    assign newCount = {count[15:8], byte_data};
    assign lastWord = (words_loaded + 16'd1) == count;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   if (accept && byte_data == SYNC_BYTE) stateNext = HDR_HI;
            HDR_HI: if (accept) stateNext = HDR_LO;
            HDR_LO: if (accept)
                        stateNext = (newCount == 16'd0 || newCount > MAX_COUNT) ? ERROR : DATA;
            DATA:   if (accept && byteIdx == 2'd3 && lastWord) stateNext = CHECK;
            CHECK:  if (accept) stateNext = (byte_data == csum) ? DONE : ERROR;
            default: stateNext = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            byteIdx      <= '0;
            wordAcc      <= '0;
            csum         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state     <= stateNext;
            mem_we    <= 1'b0;
            load_done <= (stateNext == DONE);
            cpu_reset <= (stateNext != DONE);
            error     <= (stateNext == ERROR);
            if (accept) begin
                case (state)
                    HDR_HI: count[15:8] <= byte_data;
                    HDR_LO: begin
                        count[7:0] <= byte_data;
                        byteIdx    <= '0;
                        csum       <= '0;
                    end
                    DATA: begin
                        wordAcc <= {wordAcc[15:0], byte_data};
                        csum    <= csum ^ byte_data;
                        byteIdx <= byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_wdata    <= {wordAcc, byte_data};
                            mem_addr     <= BASE_ADDR + 32'({words_loaded, 2'b00});
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes go into a scoreboard
// queue as frames are built and are popped by a monitor on every mem_we.
module tb_program_loader;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        error;
    logic [15:0] words_loaded;

    program_loader dut (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        expq[$];
    logic [7:0] txq[$];
    logic [7:0] img[8];
    int         vectors = 0;
    int         miscompares = 0;
    int         stalls = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            chk("ready_low_in_write", 32'(byte_ready), 32'd0);
            if (expq.size() == 0) begin
                chk("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int   n = 0;
        logic acc = 1'b0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!acc && n < 50) begin
            if (byte_ready) begin
                acc = 1'b1;
                @(posedge clk);
            end else begin
                stalls++;
                n++;
                @(negedge clk);
            end
        end
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic sendAll();
        while (txq.size() != 0) sendByte(txq.pop_front());
    endtask

    task automatic idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Two-word image; the checksum byte is the XOR of the eight data bytes.
    task automatic buildFrame(input bit badCsum);
        logic [7:0] cs = 8'h00;
        wr_t w;
        txq.push_back(8'hA5);
        txq.push_back(8'h00);
        txq.push_back(8'h02);
        for (int i = 0; i < 8; i++) begin
            txq.push_back(img[i]);
            cs ^= img[i];
        end
        txq.push_back(badCsum ? 8'h08 : cs);
        w.addr = BASE;      w.data = {img[0], img[1], img[2], img[3]}; expq.push_back(w);
        w.addr = BASE + 4;  w.data = {img[4], img[5], img[6], img[7]}; expq.push_back(w);
    endtask

    task automatic chkDone(input string tag);
        chk({tag, "_done"}, 32'(load_done), 32'd1);
        chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd2);
        chk({tag, "_pending"}, 32'(expq.size()), 32'd0);
    endtask

    task automatic chkError(input string tag, input logic [15:0] words);
        chk({tag, "_err"}, 32'(error), 32'd1);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'(words));
    endtask

    task automatic chkResetState(input string tag);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, BASE);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        img = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'hFF, 8'hFF};
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_gated", 32'(byte_ready), 32'd0);
        chkResetState("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd1);

        // 1: normal load
        buildFrame(1'b0);
        sendAll();
        idle();
        chkDone("c1");

        // 2: junk bytes before sync
        doReset();
        txq.push_back(8'h00); txq.push_back(8'hFF); txq.push_back(8'h5A);
        sendAll();
        idle();
        chk("c2_hunt_ready", 32'(byte_ready), 32'd1);
        chk("c2_hunt_err", 32'(error), 32'd0);
        buildFrame(1'b0);
        sendAll();
        idle();
        chkDone("c2");

        // 3: zero and oversize counts
        doReset();
        txq.push_back(8'hA5); txq.push_back(8'h00); txq.push_back(8'h00);
        sendAll();
        idle();
        chkError("c3_zero", 16'd0);
        doReset();
        txq.push_back(8'hA5); txq.push_back(8'h00); txq.push_back(8'h21);
        sendAll();
        idle();
        chkError("c3_big", 16'd0);

        // 4: checksum mismatch after both writes
        doReset();
        buildFrame(1'b1);
        sendAll();
        idle();
        chkError("c4", 16'd2);
        chk("c4_pending", 32'(expq.size()), 32'd0);

        // 5: valid held high; exactly one stall per write
        doReset();
        stalls = 0;
        buildFrame(1'b0);
        sendAll();
        idle();
        chk("c5_stalls", 32'(stalls), 32'd2);
        chkDone("c5");

        // 6: reset after the second data byte
        doReset();
        txq.push_back(8'hA5); txq.push_back(8'h00); txq.push_back(8'h02);
        txq.push_back(img[0]); txq.push_back(img[1]);
        sendAll();
        doReset();
        chkResetState("c6_rst");
        buildFrame(1'b0);
        sendAll();
        idle();
        chkDone("c6");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL global_timeout");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end
endmodule
